// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and event-index helpers for pipeline_hazard_unit and its
// performance counter bank.
//   pc_t           : 32-bit program counter value
//   EV_CYCLES      : counter index of the free-running cycle counter
//   ev_hold(s)     : counter index of "stage s held this cycle"
//   ev_episode(n,s): counter index of "stage s started a hold episode"
//   ev_redirect(n,s): counter index of "accepted redirect from stage s"
//   num_events(n)  : total number of counters for an n-stage pipeline
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef logic [31:0] pc_t;

   localparam int EV_CYCLES = 0;

   function automatic int num_events(input int n);
      return 3 * n + 1;
   endfunction

   function automatic int ev_hold(input int s);
      return 1 + s;
   endfunction

   function automatic int ev_episode(input int n, input int s);
      return 1 + n + s;
   endfunction

   function automatic int ev_redirect(input int n, input int s);
      return 1 + 2 * n + s;
   endfunction

endpackage

// File: rtl/perf_counter_bank.sv
// -----------------------------------------------------------------------------
// perf_counter_bank
// Bank of NUM_EVENTS saturating counters with a registered read port.
//   clk, rst   : clock, asynchronous active-high reset
//   inc_i      : one increment request per counter
//   clear_i    : synchronous clear of every counter, wins over increments
//   sel_i      : counter select; values >= NUM_EVENTS read as 0
//   rd_data_o  : selected counter, registered (pre-increment value)
// -----------------------------------------------------------------------------
module perf_counter_bank #(
   parameter int NUM_EVENTS = 16,
   parameter int CNT_W      = 32,
   parameter int SEL_W      = $clog2(NUM_EVENTS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_EVENTS-1:0] inc_i,
   input  logic                  clear_i,
   input  logic [SEL_W-1:0]      sel_i,
   output logic [CNT_W-1:0]      rd_data_o
);

   logic [CNT_W-1:0] cnt_q [NUM_EVENTS];
   logic [CNT_W-1:0] cnt_d [NUM_EVENTS];
   logic [CNT_W-1:0] rd_data_q;
   logic [CNT_W-1:0] rd_data_d;

   always_comb begin
      // NOTE: every variable gets a default at the top of the block so no
      // path through the if/else chain can leave it unassigned (no latch).
      rd_data_d = '0;
      for (int e = 0; e < NUM_EVENTS; e++) begin
         cnt_d[e] = cnt_q[e];
         if (clear_i) begin
            cnt_d[e] = '0;
         end else if (inc_i[e] && (cnt_q[e] != '1)) begin
            cnt_d[e] = cnt_q[e] + 1'b1;
         end
         // Read the current (pre-increment) value; unmatched selects stay 0.
         if (sel_i == SEL_W'(e)) begin
            rd_data_d = cnt_q[e];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the counters are architectural state read by software, so
         // every entry is reset rather than left as an uninitialised array.
         for (int e = 0; e < NUM_EVENTS; e++) begin
            cnt_q[e] <= '0;
         end
         rd_data_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops
         // sample their _d values from before the edge.
         for (int e = 0; e < NUM_EVENTS; e++) begin
            cnt_q[e] <= cnt_d[e];
         end
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit
// Resolves per-stage hold/redirect requests of an in-order pipeline into
// register stall/flush controls and a PC load, and keeps hazard counters and
// a stall watchdog.
//   clk, rst        : clock, asynchronous active-high reset
//   hold_req        : stage s cannot complete this cycle
//   redirect_req    : stage s requests a PC redirect
//   redirect_pc     : per-stage target PC, stage s at bits [32*s +: 32]
//   stall_o/flush_o : controls for PC (r=0), stage inputs, writeback (r=N)
//   load_pc_we      : accepted redirect, load load_pc_new_pc into PC
//   cnt_sel/cnt_clear/cnt_rd_data : performance counter access
//   stuck_o         : sticky flag, PC stalled TIMEOUT consecutive cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_unit
   import hazard_pkg::*;
#(
   parameter int  NUM_STAGES = 5,
   parameter int  DELAY_SLOT = 1,
   parameter int  CNT_W      = 32,
   parameter int  TIMEOUT    = 1024,
   localparam int NUM_EV     = num_events(NUM_STAGES),
   localparam int SEL_W      = $clog2(NUM_EV)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_STAGES-1:0]    hold_req,
   input  logic [NUM_STAGES-1:0]    redirect_req,
   input  logic [NUM_STAGES*32-1:0] redirect_pc,
   output logic [NUM_STAGES:0]      stall_o,
   output logic [NUM_STAGES:0]      flush_o,
   output logic                     load_pc_we,
   output logic [31:0]              load_pc_new_pc,
   input  logic [SEL_W-1:0]         cnt_sel,
   input  logic                     cnt_clear,
   output logic [CNT_W-1:0]         cnt_rd_data,
   output logic                     stuck_o
);

   localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam int RUN_W = $clog2(TIMEOUT + 1);

   logic                  has_win;
   logic [STG_W-1:0]      win;
   logic [STG_W-1:0]      k;
   pc_t                   win_pc;
   logic [NUM_STAGES-1:0] hold_m;
   logic [NUM_STAGES:0]   stall_eff;
   logic                  stall_run;
   logic                  accept;
   logic [NUM_EV-1:0]     ev_inc;

   logic [NUM_STAGES-1:0] hold_prev_q, hold_prev_d;
   logic [RUN_W-1:0]      run_q, run_d;
   logic                  stuck_q, stuck_d;

   // Arbitration and stall/flush resolution.
   always_comb begin
      has_win = 1'b0;
      win     = '0;
      win_pc  = '0;
      // Ascending scan: the last hit is the oldest (highest-index) requester.
      for (int s = 0; s < NUM_STAGES; s++) begin
         if (redirect_req[s]) begin
            has_win = 1'b1;
            win     = STG_W'(s);
            win_pc  = redirect_pc[s*32 +: 32];
         end
      end
      k = (win > STG_W'(DELAY_SLOT)) ? win - STG_W'(DELAY_SLOT) : '0;

      // Holds younger than the surviving window are squashed anyway.
      for (int s = 0; s < NUM_STAGES; s++) begin
         hold_m[s] = hold_req[s] & (STG_W'(s) >= k);
      end

      // A hold backs up every younger (lower-index) register.
      stall_eff             = '0;
      stall_run             = 1'b0;
      for (int s = NUM_STAGES - 1; s >= 0; s--) begin
         stall_run    = stall_run | hold_m[s];
         stall_eff[s] = stall_run;
      end

      accept = has_win & ~stall_eff[k];

      stall_o = {1'b0, stall_eff[NUM_STAGES-1:0]};
      flush_o = '0;
      // The oldest holding stage emits a bubble into the next register.
      for (int s = 0; s < NUM_STAGES; s++) begin
         flush_o[s+1] = hold_m[s] & ~stall_eff[s+1];
      end
      if (accept) begin
         for (int r = 1; r <= NUM_STAGES; r++) begin
            if (STG_W'(r) <= k && r < NUM_STAGES) flush_o[r] = 1'b1;
         end
      end
      flush_o = flush_o & ~stall_o;

      load_pc_we     = accept;
      load_pc_new_pc = accept ? win_pc : '0;

      if (rst) begin
         stall_o        = '0;
         flush_o        = '1;
         load_pc_we     = 1'b0;
         load_pc_new_pc = '0;
      end
   end

   // Counter events.
   always_comb begin
      ev_inc            = '0;
      ev_inc[EV_CYCLES] = 1'b1;
      for (int s = 0; s < NUM_STAGES; s++) begin
         ev_inc[ev_hold(s)]                = hold_req[s];
         ev_inc[ev_episode(NUM_STAGES, s)] = hold_req[s] & ~hold_prev_q[s];
         ev_inc[ev_redirect(NUM_STAGES, s)] = accept & (win == STG_W'(s));
      end
   end

   // Edge-detect history and stall watchdog.
   always_comb begin
      hold_prev_d = hold_req;
      run_d       = '0;
      stuck_d     = stuck_q;
      if (cnt_clear) begin
         stuck_d = 1'b0;
      end else if (stall_o[0]) begin
         run_d = (run_q < RUN_W'(TIMEOUT)) ? run_q + RUN_W'(1) : run_q;
         // Set on the edge where the run reaches TIMEOUT.
         if (run_q >= RUN_W'(TIMEOUT - 1)) stuck_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_prev_q <= '0;
         run_q       <= '0;
         stuck_q     <= 1'b0;
      end else begin
         hold_prev_q <= hold_prev_d;
         run_q       <= run_d;
         stuck_q     <= stuck_d;
      end
   end

   assign stuck_o = stuck_q;

   perf_counter_bank #(
      .NUM_EVENTS (NUM_EV),
      .CNT_W      (CNT_W),
      .SEL_W      (SEL_W)
   ) u_counters (
      .clk       (clk),
      .rst       (rst),
      .inc_i     (ev_inc),
      .clear_i   (cnt_clear),
      .sel_i     (cnt_sel),
      .rd_data_o (cnt_rd_data)
   );

endmodule
